shift_out_sched: RTL and testbench

- Round-robin scheduler that shares one parallel-in/serial-out shift channel among NREQ requesters.
- Accepts one word per grant, loads it into an internal shift register, and emits it LSB-first on a single serial line with valid/last framing.
- Sits between producer blocks and the board-level serial output pin.

---
 rtl/shift_out_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 31 +++
 rtl/shift_out_sched.sv | 131 +++++++++++++
 tb/tb_shift_out_sched.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_out_pkg.sv
// Shared state encoding and default sizing for the serial output scheduler.
package shift_out_pkg;

    localparam int NREQ_DEF   = 4;
    localparam int WIDTH_DEF  = 32;
    localparam int CWIDTH_DEF = 5;
    localparam int IDW_DEF    = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after the last winner, wrapping.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    input  logic            enable,
    output logic            any,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  id
);

    logic [IDW-1:0] cand;

    always_comb begin
        any   = 1'b0;
        grant = '0;
        id    = '0;
        cand  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = IDW'((int'(last) + k) % NREQ);
            if (enable && !any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                id          = cand;
            end
        end
    end

endmodule

// File: rtl/shift_out_sched.sv
// Round-robin scheduler sharing one LSB-first serial channel among NREQ producers.
// Define SHIFT_OUT_SCHED_PARITY_EN to append an even-parity bit to every frame.
module shift_out_sched
    import shift_out_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    parameter int CWIDTH = CWIDTH_DEF,
    parameter int IDW    = IDW_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data,
    output logic [NREQ-1:0]       grant,
    output logic                  sout,
    output logic                  sout_valid,
    output logic                  sout_last,
    output logic                  busy,
    output logic                  done,
    output logic [IDW-1:0]        done_id
);

    // Explicit terminal index so a full-range counter never has to wrap.
    localparam logic [CWIDTH-1:0] LAST_IDX = CWIDTH'(WIDTH - 1);

    state_t            state_reg;
    logic [WIDTH-1:0]  shift_reg;
    logic [CWIDTH-1:0] index_reg;
    logic [IDW-1:0]    last_reg;
    logic [IDW-1:0]    cur_id_reg;
    logic [NREQ-1:0]   grant_reg;

    logic [WIDTH-1:0]  word_arr [NREQ];
    logic              arb_any;
    logic [NREQ-1:0]   arb_grant;
    logic [IDW-1:0]    arb_id;
    logic [WIDTH-1:0]  sel_word;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_word
        assign word_arr[gi] = data[gi*WIDTH +: WIDTH];
    end

    assign sel_word = word_arr[arb_id];

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req    (req),
        .last   (last_reg),
        .enable (state_reg == ST_IDLE),
        .any    (arb_any),
        .grant  (arb_grant),
        .id     (arb_id)
    );

`ifdef SHIFT_OUT_SCHED_PARITY_EN
    logic par_reg;
    logic par_phase_reg;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            shift_reg     <= '0;
            index_reg     <= '0;
            last_reg      <= IDW'(NREQ - 1);
            cur_id_reg    <= '0;
            grant_reg     <= '0;
`ifdef SHIFT_OUT_SCHED_PARITY_EN
            par_reg       <= 1'b0;
            par_phase_reg <= 1'b0;
`endif
        end else begin
            grant_reg <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (arb_any) begin
                        shift_reg     <= sel_word;
                        index_reg     <= '0;
                        last_reg      <= arb_id;
                        cur_id_reg    <= arb_id;
                        grant_reg     <= arb_grant;
                        state_reg     <= ST_SHIFT;
`ifdef SHIFT_OUT_SCHED_PARITY_EN
                        par_reg       <= ^sel_word;
                        par_phase_reg <= 1'b0;
`endif
                    end
                end
                ST_SHIFT: begin
`ifdef SHIFT_OUT_SCHED_PARITY_EN
                    // Index parks on the last data bit while the parity bit goes out.
                    if (par_phase_reg) begin
                        par_phase_reg <= 1'b0;
                        state_reg     <= ST_GAP;
                    end else if (index_reg == LAST_IDX) begin
                        par_phase_reg <= 1'b1;
                    end else begin
                        index_reg <= index_reg + 1'b1;
                    end
`else
                    if (index_reg == LAST_IDX) begin
                        state_reg <= ST_GAP;
                    end else begin
                        index_reg <= index_reg + 1'b1;
                    end
`endif
                end
                ST_GAP:  state_reg <= ST_IDLE;
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign sout_valid = (state_reg == ST_SHIFT);
    assign busy       = (state_reg != ST_IDLE);
    assign done       = (state_reg == ST_GAP);
    assign done_id    = done ? cur_id_reg : '0;
    assign grant      = grant_reg;

`ifdef SHIFT_OUT_SCHED_PARITY_EN
    assign sout      = sout_valid && (par_phase_reg ? par_reg : shift_reg[index_reg]);
    assign sout_last = sout_valid && par_phase_reg;
`else
    assign sout      = sout_valid && shift_reg[index_reg];
    assign sout_last = sout_valid && (index_reg == LAST_IDX);
`endif

endmodule

// File: tb/tb_shift_out_sched.sv
// Self-checking bench for shift_out_sched: fixed and random frames against a frame-level model.
module tb_shift_out_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int IDW   = 2;
`ifdef SHIFT_OUT_SCHED_PARITY_EN
    localparam int FL  = WIDTH + 1;
    localparam int FL8 = 9;
`else
    localparam int FL  = WIDTH;
    localparam int FL8 = 8;
`endif

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       grant;
    logic                  sout, sout_valid, sout_last, busy, done;
    logic [IDW-1:0]        done_id;

    logic [NREQ-1:0]       req8;
    logic [NREQ*8-1:0]     data8;
    logic [NREQ-1:0]       grant8;
    logic                  sout8, sout_valid8, sout_last8, busy8, done8;
    logic [IDW-1:0]        done_id8;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int model_last;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    shift_out_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .CWIDTH(5), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .data(data), .grant(grant),
        .sout(sout), .sout_valid(sout_valid), .sout_last(sout_last),
        .busy(busy), .done(done), .done_id(done_id)
    );

    shift_out_sched #(.NREQ(NREQ), .WIDTH(8), .CWIDTH(3), .IDW(IDW)) dut8 (
        .clk(clk), .rst_n(rst_n), .req(req8), .data(data8), .grant(grant8),
        .sout(sout8), .sout_valid(sout_valid8), .sout_last(sout_last8),
        .busy(busy8), .done(done8), .done_id(done_id8)
    );

    // Expected serial frame: data LSB first, then even parity when enabled.
    function automatic logic [63:0] exp_vec(input logic [WIDTH-1:0] w);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < FL; i++)
            v[i] = (i < WIDTH) ? w[i] : (($countones(w) % 2) == 1);
        return v;
    endfunction

    // Round-robin rule: first requester after the previous winner, wrapping.
    function automatic int pick(input logic [NREQ-1:0] r, input int lst);
        for (int k = 1; k <= NREQ; k++)
            if (r[(lst + k) % NREQ]) return (lst + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [WIDTH-1:0] word_of(input int i);
        logic [WIDTH-1:0] w;
        w = data[i*WIDTH +: WIDTH];
        return w;
    endfunction

    // Observes one frame from the grant sample to the gap sample.
    task automatic capture(input bit drop, output logic [NREQ-1:0] g, output logic [NREQ-1:0] g2,
                           output logic [63:0] bits, output int nv, output int lp,
                           output logic dn, output logic [IDW-1:0] did, output logic bz,
                           output int gc, output bit to);
        to = 1; g = '0; g2 = '0; bits = '0; nv = 0; lp = -1;
        dn = 1'b0; did = '0; bz = 1'b1; gc = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (grant != '0) begin
                to = 0;
                break;
            end
        end
        if (to) return;
        g  = grant;
        gc = cyc;
        if (drop) req = req & ~grant;
        while (sout_valid && nv < 64) begin
            bits[nv] = sout;
            if (sout_last) lp = nv;
            bz &= busy;
            nv++;
            @(negedge clk);
            if (nv == 1) g2 = grant;
        end
        dn  = done;
        did = done_id;
        bz &= busy;
        $display("frame grant=%b bits=%0d last_at=%0d done=%b done_id=%0d cyc=%0d", g, nv, lp, dn, did, gc);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req = '0; data = '0; req8 = '0; data8 = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({grant, sout, sout_valid, sout_last, busy, done, done_id} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {grant, sout, sout_valid, sout_last, busy, done, done_id});
        end
        checks++;
        if ({grant8, sout8, sout_valid8, sout_last8, busy8, done8, done_id8} !== '0) begin
            errors++;
            $display("FAIL reset_outputs8 got=%h want=0", {grant8, sout8, sout_valid8, sout_last8, busy8, done8, done_id8});
        end
        rst_n = 1'b1;
        model_last = NREQ - 1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, sout_valid, grant} !== '0) begin
            errors++;
            $display("FAIL idle_quiet got=%h want=0", {busy, sout_valid, grant});
        end
    endtask

    task automatic test_single();
        logic [NREQ-1:0] g, g2; logic [63:0] bits; int nv, lp, gc; logic dn, bz;
        logic [IDW-1:0] did; bit to; logic [63:0] ev;
        data[0 +: WIDTH] = 32'hA5A5_0F0F;
        req = 4'b0001;
        capture(1'b1, g, g2, bits, nv, lp, dn, did, bz, gc, to);
        ev = exp_vec(32'hA5A5_0F0F);
        model_last = 0;
        checks++;
        if (to) begin errors++; $display("FAIL single_timeout no grant seen"); return; end
        checks++;
        if (g !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b want=0001", g); end
        checks++;
        if (g2 !== 4'b0000) begin errors++; $display("FAIL single_grant_pulse got=%b want=0000", g2); end
        checks++;
        if (nv !== FL) begin errors++; $display("FAIL single_len got=%0d want=%0d", nv, FL); end
        checks++;
        if (lp !== FL - 1) begin errors++; $display("FAIL single_last got=%0d want=%0d", lp, FL - 1); end
        checks++;
        if (bits[FL-1:0] !== ev[FL-1:0]) begin errors++; $display("FAIL single_bits got=%h want=%h", bits[FL-1:0], ev[FL-1:0]); end
        checks++;
        if ({dn, did, bz} !== {1'b1, 2'd0, 1'b1}) begin
            errors++; $display("FAIL single_done got=%b/%0d/%b want=1/0/1", dn, did, bz);
        end
    endtask

    task automatic test_fairness();
        logic [NREQ-1:0] g, g2; logic [63:0] bits; int nv, lp, gc, prev_gc, exp_id;
        logic dn, bz; logic [IDW-1:0] did; bit to; logic [63:0] ev;
        for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = $urandom;
        req = 4'b1111;
        prev_gc = 0;
        for (int f = 0; f < 5; f++) begin
            exp_id = pick(req, model_last);
            capture(1'b0, g, g2, bits, nv, lp, dn, did, bz, gc, to);
            if (f == 4) req = '0;
            checks++;
            if (to) begin errors++; $display("FAIL fair_timeout frame=%0d", f); return; end
            ev = exp_vec(word_of(exp_id));
            checks++;
            if (g !== NREQ'(1 << exp_id) || did !== IDW'(exp_id)) begin
                errors++; $display("FAIL fair_order frame=%0d got=%b/%0d want_id=%0d", f, g, did, exp_id);
            end
            checks++;
            if (bits[FL-1:0] !== ev[FL-1:0] || lp !== FL - 1) begin
                errors++; $display("FAIL fair_bits frame=%0d got=%h want=%h", f, bits[FL-1:0], ev[FL-1:0]);
            end
            if (f > 0) begin
                checks++;
                if (gc - prev_gc !== FL + 2) begin
                    errors++; $display("FAIL fair_spacing frame=%0d got=%0d want=%0d", f, gc - prev_gc, FL + 2);
                end
            end
            prev_gc = gc;
            model_last = exp_id;
        end
    endtask

    task automatic test_late_request();
        logic [NREQ-1:0] g, g2; logic [63:0] bits; int nv, lp, gc, gc1;
        logic dn, bz; logic [IDW-1:0] did; bit to; logic [63:0] ev;
        logic [WIDTH-1:0] w1, w2;
        w1 = $urandom; w2 = $urandom;
        data[1*WIDTH +: WIDTH] = w1;
        req = 4'b0010;
        fork
            capture(1'b1, g, g2, bits, nv, lp, dn, did, bz, gc, to);
            begin
                repeat (10) @(negedge clk);
                req[2] = 1'b1;
                data[2*WIDTH +: WIDTH] = $urandom;
                repeat (10) @(negedge clk);
                data[2*WIDTH +: WIDTH] = w2;
            end
        join
        gc1 = gc;
        ev = exp_vec(w1);
        checks++;
        if (to || g !== 4'b0010 || bits[FL-1:0] !== ev[FL-1:0]) begin
            errors++; $display("FAIL late_first got=%b bits=%h want=0010 bits=%h", g, bits[FL-1:0], ev[FL-1:0]);
        end
        fork
            capture(1'b1, g, g2, bits, nv, lp, dn, did, bz, gc, to);
            begin
                repeat (3) @(negedge clk);
                data[2*WIDTH +: WIDTH] = ~w2;
            end
        join
        model_last = 2;
        ev = exp_vec(w2);
        checks++;
        if (to || g !== 4'b0100 || did !== 2'd2) begin
            errors++; $display("FAIL late_grant got=%b/%0d want=0100/2", g, did);
        end
        checks++;
        if (bits[FL-1:0] !== ev[FL-1:0]) begin
            errors++; $display("FAIL late_capture got=%h want=%h", bits[FL-1:0], ev[FL-1:0]);
        end
        checks++;
        if (gc - gc1 !== FL + 2) begin
            errors++; $display("FAIL late_spacing got=%0d want=%0d", gc - gc1, FL + 2);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [NREQ-1:0] g, g2; logic [63:0] bits; int nv, lp, gc;
        logic dn, bz, seen_done; logic [IDW-1:0] did; bit to; logic [63:0] ev;
        logic [WIDTH-1:0] w3;
        bit got;
        data[0 +: WIDTH] = $urandom;
        req = 4'b0001;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (grant != '0) begin got = 1; break; end
        end
        req = '0;
        checks++;
        if (!got) begin errors++; $display("FAIL rstmid_timeout no grant seen"); return; end
        repeat (10) @(negedge clk);
        checks++;
        if (sout_valid !== 1'b1) begin errors++; $display("FAIL rstmid_inframe got=%b want=1", sout_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({grant, sout, sout_valid, sout_last, busy, done, done_id} !== '0) begin
            errors++; $display("FAIL rstmid_async got=%h want=0", {grant, sout, sout_valid, sout_last, busy, done, done_id});
        end
        seen_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen_done |= done;
        end
        rst_n = 1'b1;
        model_last = NREQ - 1;
        repeat (3) begin
            @(negedge clk);
            seen_done |= done;
        end
        checks++;
        if (seen_done !== 1'b0) begin errors++; $display("FAIL rstmid_no_done got=%b want=0", seen_done); end
        w3 = $urandom;
        data[3*WIDTH +: WIDTH] = w3;
        req = 4'b1000;
        capture(1'b1, g, g2, bits, nv, lp, dn, did, bz, gc, to);
        model_last = 3;
        ev = exp_vec(w3);
        checks++;
        if (to || g !== 4'b1000 || did !== 2'd3 || dn !== 1'b1) begin
            errors++; $display("FAIL rstmid_req3 got=%b/%0d/%b want=1000/3/1", g, did, dn);
        end
        checks++;
        if (bits[FL-1:0] !== ev[FL-1:0]) begin
            errors++; $display("FAIL rstmid_bits got=%h want=%h", bits[FL-1:0], ev[FL-1:0]);
        end
    endtask

    task automatic test_random();
        logic [NREQ-1:0] g, g2; logic [63:0] bits; int nv, lp, gc, exp_id;
        logic dn, bz; logic [IDW-1:0] did; bit to; logic [63:0] ev;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < NREQ; i++) data[i*WIDTH +: WIDTH] = $urandom;
            req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            exp_id = pick(req, model_last);
            ev = exp_vec(word_of(exp_id));
            capture(1'b1, g, g2, bits, nv, lp, dn, did, bz, gc, to);
            model_last = exp_id;
            checks++;
            if (to || g !== NREQ'(1 << exp_id) || did !== IDW'(exp_id)) begin
                errors++; $display("FAIL rand_grant iter=%0d got=%b/%0d want_id=%0d", t, g, did, exp_id);
            end
            checks++;
            if (bits[FL-1:0] !== ev[FL-1:0] || nv !== FL || lp !== FL - 1) begin
                errors++; $display("FAIL rand_frame iter=%0d got=%h len=%0d want=%h len=%0d", t, bits[FL-1:0], nv, ev[FL-1:0], FL);
            end
        end
        req = '0;
    endtask

    // Full-range counter instance: 8-bit words on a 3-bit index.
    task automatic test_width8();
        logic [7:0] w8; int nv, lp; logic ok_bits, dn, restarted; bit got;
        w8 = 8'hFF;
        data8[0 +: 8] = w8;
        req8 = 4'b0001;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (grant8 != '0) begin got = 1; break; end
        end
        req8 = '0;
        checks++;
        if (!got) begin errors++; $display("FAIL w8_timeout no grant seen"); return; end
        nv = 0; lp = -1; ok_bits = 1'b1;
        while (sout_valid8 && nv < 64) begin
            if (sout8 !== ((nv < 8) ? w8[nv[2:0]] : ^w8)) ok_bits = 1'b0;
            if (sout_last8) lp = nv;
            nv++;
            @(negedge clk);
        end
        dn = done8;
        restarted = 1'b0;
        repeat (12) begin
            @(negedge clk);
            restarted |= sout_valid8;
        end
        $display("frame8 bits=%0d last_at=%0d done=%b", nv, lp, dn);
        checks++;
        if (nv !== FL8 || lp !== FL8 - 1) begin
            errors++; $display("FAIL w8_len got=%0d/%0d want=%0d/%0d", nv, lp, FL8, FL8 - 1);
        end
        checks++;
        if (ok_bits !== 1'b1 || dn !== 1'b1 || restarted !== 1'b0) begin
            errors++; $display("FAIL w8_frame got bits_ok=%b done=%b restart=%b want=1/1/0", ok_bits, dn, restarted);
        end
    endtask

    task automatic test_parity_words();
        logic [NREQ-1:0] g, g2; logic [63:0] bits; int nv, lp, gc;
        logic dn, bz; logic [IDW-1:0] did; bit to; logic [63:0] ev;
        logic [WIDTH-1:0] words [2];
        words[0] = 32'h0000_0007;
        words[1] = 32'h0000_0003;
        for (int k = 0; k < 2; k++) begin
            data[0 +: WIDTH] = words[k];
            req = 4'b0001;
            capture(1'b1, g, g2, bits, nv, lp, dn, did, bz, gc, to);
            model_last = 0;
            ev = exp_vec(words[k]);
            checks++;
            if (to || bits[FL-1:0] !== ev[FL-1:0] || lp !== FL - 1) begin
                errors++; $display("FAIL parity_word k=%0d got=%h last=%0d want=%h last=%0d", k, bits[FL-1:0], lp, ev[FL-1:0], FL - 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_late_request();
        test_reset_mid_frame();
        test_random();
        test_parity_words();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout bench did not finish");
        $fatal(1);
    end

endmodule
